// File: rtl/tap_scan_delay_mux.sv
// Tap delay line plus scanner feeding one tap per handshake to a shared MAC.
// Optional reverse scan direction: define TAP_SCAN_REVERSE_EN to add iScanDir.
module tap_scan_delay_mux #(
    parameter int WIDTH    = 3,
    parameter int NUM_TAPS = 10,
    parameter int SEL_W    = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iFlush,
    input  logic             iSampleVld,
    input  logic [WIDTH-1:0] iSample,
`ifdef TAP_SCAN_REVERSE_EN
    input  logic             iScanDir,
`endif
    output logic             oSampleRdy,
    output logic [WIDTH-1:0] oTap,
    output logic [SEL_W-1:0] oTapIdx,
    output logic             oTapVld,
    input  logic             iTapRdy,
    output logic             oLast,
    output logic             oDrop
);

    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_TAPS - 1);
    localparam logic [SEL_W:0]   NUM_TAPS_X = (SEL_W + 1)'(NUM_TAPS);

    typedef enum logic {
        IDLE,
        SCAN
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] idxNext;
    logic [SEL_W-1:0] startIdx;
    logic [SEL_W-1:0] stepIdx;
    logic [WIDTH-1:0] taps [NUM_TAPS];
    logic             idxOk;
    logic             lastHit;
    logic             handshake;
    logic             accept;

    assign accept    = (state == IDLE) && iSampleVld && !iFlush;
    assign handshake = oTapVld && iTapRdy;
    assign idxOk     = ({1'b0, idx} < NUM_TAPS_X);

`ifdef TAP_SCAN_REVERSE_EN
    logic dirQ;

    // Scan direction latched at sample accept, held for the whole scan
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            dirQ <= 1'b0;
        end else if (iFlush) begin
            dirQ <= 1'b0;
        end else if (accept) begin
            dirQ <= iScanDir;
        end
    end

    assign startIdx = iScanDir ? LAST_IDX : '0;
    assign stepIdx  = dirQ ? (idx - 1'b1) : (idx + 1'b1);
    assign lastHit  = dirQ ? (idx == '0) : (idx == LAST_IDX);
`else
    assign startIdx = '0;
    assign stepIdx  = idx + 1'b1;
    assign lastHit  = (idx == LAST_IDX);
`endif

    // State and index registers
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    // Next state: flush wins, then accept / handshake; bad index bails to IDLE
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        if (iFlush) begin
            stateNext = IDLE;
            idxNext   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iSampleVld) begin
                        stateNext = SCAN;
                        idxNext   = startIdx;
                    end
                end
                SCAN: begin
                    if (!idxOk) begin
                        stateNext = IDLE;
                        idxNext   = '0;
                    end else if (handshake) begin
                        if (lastHit) begin
                            stateNext = IDLE;
                            idxNext   = '0;
                        end else begin
                            idxNext = stepIdx;
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    idxNext   = '0;
                end
            endcase
        end
    end

    // Outputs: IDLE forces the tap bus to zero, SCAN presents tap[idx]
    always_comb begin
        oSampleRdy = 1'b0;
        oTapVld    = 1'b0;
        oTap       = '0;
        oTapIdx    = '0;
        oLast      = 1'b0;
        unique case (state)
            IDLE: begin
                oSampleRdy = 1'b1;
            end
            SCAN: begin
                oTapVld = 1'b1;
                oTapIdx = idx;
                oLast   = lastHit && idxOk;
                for (int k = 0; k < NUM_TAPS; k++) begin
                    if (idx == SEL_W'(k)) begin
                        oTap = taps[k];
                    end
                end
            end
            default: begin
                oSampleRdy = 1'b0;
            end
        endcase
    end

    // Delay line: cleared by flush, shifted on each accepted sample
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps[k] <= '0;
            end
        end else if (iFlush) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps[k] <= '0;
            end
        end else if (accept) begin
            taps[0] <= iSample;
            for (int k = 1; k < NUM_TAPS; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    // Drop pulse for a sample offered while a scan is in progress
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oDrop <= 1'b0;
        end else if (iFlush) begin
            oDrop <= 1'b0;
        end else begin
            oDrop <= (state == SCAN) && iSampleVld;
        end
    end

endmodule

// File: tb/tb_tap_scan_delay_mux.sv
// Directed bench for tap_scan_delay_mux with a shadow delay-line model.
// Define TAP_SCAN_REVERSE_EN to also exercise the reverse scan.
module tb_tap_scan_delay_mux;

    localparam int WIDTH    = 3;
    localparam int NUM_TAPS = 10;
    localparam int SEL_W    = 4;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iFlush;
    logic             iSampleVld;
    logic [WIDTH-1:0] iSample;
    logic             iScanDir;
    logic             oSampleRdy;
    logic [WIDTH-1:0] oTap;
    logic [SEL_W-1:0] oTapIdx;
    logic             oTapVld;
    logic             iTapRdy;
    logic             oLast;
    logic             oDrop;

    int               checks = 0;
    int               errors = 0;
    int               cyc;
    logic [WIDTH-1:0] model [NUM_TAPS];

    tap_scan_delay_mux #(
        .WIDTH    (WIDTH),
        .NUM_TAPS (NUM_TAPS),
        .SEL_W    (SEL_W)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iFlush     (iFlush),
        .iSampleVld (iSampleVld),
        .iSample    (iSample),
`ifdef TAP_SCAN_REVERSE_EN
        .iScanDir   (iScanDir),
`endif
        .oSampleRdy (oSampleRdy),
        .oTap       (oTap),
        .oTapIdx    (oTapIdx),
        .oTapVld    (oTapVld),
        .iTapRdy    (iTapRdy),
        .oLast      (oLast),
        .oDrop      (oDrop)
    );

    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic checkEq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < NUM_TAPS; k++) model[k] = '0;
    endtask

    // Offer one sample while IDLE; returns on the negedge the scan starts
    task automatic sendSample(input logic [WIDTH-1:0] v);
        checkEq("acceptRdy", oSampleRdy, 1);
        iSampleVld = 1'b1;
        iSample    = v;
        @(negedge iClk);
        iSampleVld = 1'b0;
        for (int k = NUM_TAPS - 1; k > 0; k--) model[k] = model[k-1];
        model[0] = v;
    endtask

    // Walk a scan checking every presented tap; optional stall, drop, abort
    task automatic scanRun(input int stallIdx, input int dropIdx,
                           input int abortIdx, output int cycles);
        int   i;
        int   stalls;
        int   pos;
        logic expDrop;
        i       = 0;
        stalls  = 0;
        expDrop = 1'b0;
        cycles  = 0;
        while (i < NUM_TAPS && i != abortIdx && cycles < 40) begin
            pos = iScanDir ? (NUM_TAPS - 1 - i) : i;
            checkEq("tapVld", oTapVld, 1);
            checkEq("tapIdx", oTapIdx, pos);
            checkEq("tapVal", oTap, model[pos]);
            checkEq("last", oLast, (i == NUM_TAPS - 1));
            checkEq("scanRdy", oSampleRdy, 0);
            checkEq("drop", oDrop, expDrop);
            expDrop    = (i == dropIdx);
            iSampleVld = expDrop;
            iSample    = 3'd7;
            if (i == stallIdx && stalls < 3) begin
                iTapRdy = 1'b0;
                stalls++;
            end else begin
                iTapRdy = 1'b1;
                i++;
            end
            @(negedge iClk);
            cycles++;
        end
        iSampleVld = 1'b0;
        iTapRdy    = 1'b1;
        checkEq("scanBound", (cycles < 40), 1);
        if (i == NUM_TAPS) begin
            checkEq("endVld", oTapVld, 0);
            checkEq("endRdy", oSampleRdy, 1);
            checkEq("endDrop", oDrop, expDrop);
            checkEq("endTap", oTap, 0);
        end
    endtask

    initial begin
        iRst       = 1'b1;
        iFlush     = 1'b0;
        iSampleVld = 1'b0;
        iSample    = '0;
        iScanDir   = 1'b0;
        iTapRdy    = 1'b1;
        clearModel();
        repeat (2) @(negedge iClk);
        checkEq("rstRdy", oSampleRdy, 1);
        checkEq("rstVld", oTapVld, 0);
        checkEq("rstTap", oTap, 0);
        checkEq("rstIdx", oTapIdx, 0);
        checkEq("rstLast", oLast, 0);
        checkEq("rstDrop", oDrop, 0);
        iRst = 1'b0;
        @(negedge iClk);

        for (int v = 1; v <= 4; v++) begin
            sendSample(WIDTH'(v));
            scanRun(-1, -1, -1, cyc);
            checkEq("scanCycles", cyc, NUM_TAPS);
        end

        sendSample(3'd5);
        scanRun(4, -1, -1, cyc);
        checkEq("stallCycles", cyc, 13);

        sendSample(3'd6);
        scanRun(-1, 2, -1, cyc);
        sendSample(3'd1);
        scanRun(-1, -1, -1, cyc);

        for (int n = 0; n < NUM_TAPS; n++) begin
            sendSample(3'd7);
            scanRun(-1, -1, -1, cyc);
        end
        iFlush     = 1'b1;
        iSampleVld = 1'b1;
        iSample    = 3'd3;
        @(negedge iClk);
        iFlush     = 1'b0;
        iSampleVld = 1'b0;
        clearModel();
        checkEq("flushRdy", oSampleRdy, 1);
        checkEq("flushVld", oTapVld, 0);
        checkEq("flushDrop", oDrop, 0);
        sendSample(3'd5);
        scanRun(-1, -1, -1, cyc);

        sendSample(3'd2);
        scanRun(-1, -1, 3, cyc);
        iFlush = 1'b1;
        @(negedge iClk);
        iFlush = 1'b0;
        clearModel();
        checkEq("midFlushVld", oTapVld, 0);
        checkEq("midFlushRdy", oSampleRdy, 1);
        sendSample(3'd4);
        scanRun(-1, -1, -1, cyc);

        sendSample(3'd6);
        scanRun(-1, -1, 6, cyc);
        checkEq("preRstIdx", oTapIdx, 6);
        iRst = 1'b1;
        #1;
        checkEq("asyncRdy", oSampleRdy, 1);
        checkEq("asyncVld", oTapVld, 0);
        checkEq("asyncTap", oTap, 0);
        checkEq("asyncIdx", oTapIdx, 0);
        checkEq("asyncLast", oLast, 0);
        @(negedge iClk);
        iRst = 1'b0;
        clearModel();
        @(negedge iClk);
        sendSample(3'd3);
        scanRun(-1, -1, -1, cyc);

`ifdef TAP_SCAN_REVERSE_EN
        for (int v = 1; v < NUM_TAPS; v++) begin
            sendSample(WIDTH'(v));
            scanRun(-1, -1, -1, cyc);
        end
        iScanDir = 1'b1;
        sendSample(WIDTH'(NUM_TAPS));
        scanRun(-1, -1, -1, cyc);
        checkEq("revCycles", cyc, NUM_TAPS);
        iScanDir = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
